// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded bursts and a shared 4:1 data mux.
// A release re-arbitrates on the same edge, so back-to-back grants need no idle cycle.
module rr_arbiter4 #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             ready,
    output logic [3:0]       grant,
    output logic [1:0]       select,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             last,
    output logic             busy
);

    localparam logic       IDLE     = 1'b0;
    localparam logic       XFER     = 1'b1;
    localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

    logic       state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;

    logic       in_xfer;
    logic       beat;
    logic       last_beat;
    logic       release_w;
    logic [1:0] next_ptr;

    // First set request bit scanning upward from p; the lowest offset wins.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] idx;
        w = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction

    assign in_xfer   = (state_q == XFER);
    assign beat      = in_xfer && ready;
    assign last_beat = (cnt_q == LAST_CNT);
    assign next_ptr  = sel_q + 2'd1;
    assign release_w = in_xfer && (beat ? (last_beat || !req[sel_q]) : !req[sel_q]);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        if (!in_xfer) begin
            if (|req) begin
                state_d = XFER;
                sel_d   = pick(req, ptr_q);
                cnt_d   = '0;
            end
        end else if (release_w) begin
            // The outgoing requester sits at lowest priority under the new pointer.
            ptr_d = next_ptr;
            cnt_d = '0;
            if (|req) begin
                sel_d = pick(req, next_ptr);
            end else begin
                state_d = IDLE;
            end
        end else if (beat) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = in_xfer;
    assign out_valid = in_xfer;
    assign select    = sel_q;
    assign grant     = in_xfer ? (4'd1 << sel_q) : 4'd0;
    assign last      = in_xfer && last_beat;

    always_comb begin
        out = '0;
        if (in_xfer) begin
            case (sel_q)
                2'd0:    out = in0;
                2'd1:    out = in1;
                2'd2:    out = in2;
                default: out = in3;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Random and scenario stimulus on two arbiters (MAX_BURST 4 and 1) sharing inputs,
// each compared every cycle against a transaction-level round-robin model.
module tb_rr_arbiter4;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] din [4];
    logic        ready;

    logic [3:0]  gnt  [2];
    logic [1:0]  sel  [2];
    logic [31:0] dout [2];
    logic        ov   [2];
    logic        lst  [2];
    logic        bsy  [2];

    int n_checks;
    int n_errs;

    // model state per instance
    int  mb    [2];
    bit  m_own [2];
    int  m_sel [2];
    int  m_ptr [2];
    int  m_cnt [2];

    rr_arbiter4 #(.WIDTH(32), .MAX_BURST(4)) u_dut4 (
        .clk(clk), .reset(reset), .req(req),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .ready(ready), .grant(gnt[0]), .select(sel[0]), .out(dout[0]),
        .out_valid(ov[0]), .last(lst[0]), .busy(bsy[0])
    );

    rr_arbiter4 #(.WIDTH(32), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .ready(ready), .grant(gnt[1]), .select(sel[1]), .out(dout[1]),
        .out_valid(ov[1]), .last(lst[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int arb(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = 0; m_sel[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
        end
    endtask

    // Advance the model by one rising edge using the inputs held across it.
    task automatic model_step();
        bit beat, rel;
        if (reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (!m_own[k]) begin
                if (req != 0) begin
                    m_own[k] = 1; m_sel[k] = arb(req, m_ptr[k]); m_cnt[k] = 0;
                end
            end else begin
                beat = ready;
                if (beat) rel = (m_cnt[k] + 1 >= mb[k]) || !req[m_sel[k]];
                else      rel = !req[m_sel[k]];
                if (rel) begin
                    m_ptr[k] = (m_sel[k] + 1) % 4;
                    m_cnt[k] = 0;
                    if (req != 0) m_sel[k] = arb(req, m_ptr[k]);
                    else          m_own[k] = 0;
                end else if (beat) begin
                    m_cnt[k]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            logic [3:0]  eg;
            logic [31:0] eo;
            eg = m_own[k] ? 4'(1 << m_sel[k]) : 4'd0;
            eo = m_own[k] ? din[m_sel[k]] : 32'd0;
            check($sformatf("grant[%0d]", k),     64'(gnt[k]),  64'(eg));
            check($sformatf("select[%0d]", k),    64'(sel[k]),  64'(m_sel[k]));
            check($sformatf("out[%0d]", k),       64'(dout[k]), 64'(eo));
            check($sformatf("out_valid[%0d]", k), 64'(ov[k]),   64'(m_own[k]));
            check($sformatf("busy[%0d]", k),      64'(bsy[k]),  64'(m_own[k]));
            check($sformatf("last[%0d]", k),      64'(lst[k]),
                  64'(m_own[k] && (m_cnt[k] == mb[k] - 1)));
        end
    endtask

    // One cycle: drive at negedge, check settled outputs, update model at posedge.
    task automatic cycle(input logic r, input logic [3:0] rq, input logic rd);
        @(negedge clk);
        reset = r; req = rq; ready = rd;
        #1;
        compare_all();
        @(posedge clk);
        model_step();
    endtask

    initial begin
        logic [3:0] rq;
        n_checks = 0; n_errs = 0;
        mb[0] = 4; mb[1] = 1;
        reset = 1'b1; req = 4'd0; ready = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        model_reset();

        // Single requester, in0=5, always ready: bursts of 4 then re-grant without a gap.
        @(negedge clk); din[0] = 32'd5;
        for (int c = 0; c < 30; c++) cycle(1'b0, 4'b0001, 1'b1);

        // All requesting: strict rotation with continuous out_valid.
        cycle(1'b1, 4'b0000, 1'b0);
        for (int c = 0; c < 50; c++) begin
            for (int i = 0; i < 4; i++) din[i] = $urandom;
            cycle(1'b0, 4'b1111, 1'b1);
        end

        // Stalls with live data changes on the granted input.
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < 4; i++) din[i] = $urandom;
            cycle(1'b0, 4'b0110 | ((c % 7 == 0) ? 4'b1001 : 4'b0000), ($urandom_range(0, 2) == 0));
        end

        // Pattern 1011 held: requester 2 never wins.
        for (int c = 0; c < 30; c++) cycle(1'b0, 4'b1011, 1'b1);

        // Random traffic with occasional reset, including mid-burst with ready high.
        rq = 4'd0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++) begin
                din[i] = $urandom;
                if ($urandom_range(0, 5) == 0) rq[i] = ~rq[i];
            end
            cycle(($urandom_range(0, 39) == 0), rq, ($urandom_range(0, 9) < 7));
        end

        @(negedge clk);
        reset = 1'b0; req = 4'd0; ready = 1'b0;
        #1;
        compare_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter WIDTH, default 32, data width of each requester input and of out.
REQ-002 Parameter MAX_BURST, default 4, maximum beats per grant; legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-requester request; bit i belongs to requester i.
REQ-006 in0, in1, in2, in3  input  WIDTH each  requester data.
REQ-007 ready  input  1  downstream accepts the current beat.
REQ-008 grant  output  4  one-hot grant, or all-zero.
REQ-009 select  output  2  encoded index of the granted requester; drives the shared 4:1 data mux.
REQ-010 out  output  WIDTH  shared data: in[select] when out_valid=1, else 0.
REQ-011 out_valid  output  1  a beat is presented on out.
REQ-012 last  output  1  current beat is the final beat allowed in this grant.
REQ-013 busy  output  1  arbiter is in XFER.

Function
REQ-014 The FSM SHALL have two states, IDLE and XFER, plus a 2-bit round-robin pointer ptr and a beat counter cnt.
REQ-015 In IDLE, grant=0, out_valid=0, last=0, busy=0, and select holds its last value.
REQ-016 Arbitration SHALL pick the first asserted req bit in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the winner is w.
REQ-017 From IDLE with req!=0 at an edge: next cycle state=XFER, grant=onehot(w), select=w, cnt=0 (1-cycle latency from request to grant).
REQ-018 In XFER, out_valid=1, busy=1, out=in[select] combinationally, and last=(cnt==MAX_BURST-1).
REQ-019 Beat: an edge with out_valid=1 and ready=1; cnt SHALL increment by one on each beat.
REQ-020 Without a beat (ready=0), grant, select and cnt SHALL hold while req[w]=1; out tracks in[select] live.
REQ-021 Release SHALL occur at an edge where (beat and (last=1 or req[w]=0)) or (no beat and req[w]=0).
REQ-022 On release, ptr SHALL become w+1 mod 4.
REQ-023 On release, arbitration SHALL re-run on the same-edge req using the new ptr: if any req is set, go directly to XFER with the new winner and cnt=0 (no idle bubble); otherwise go to IDLE.
REQ-024 A requester still requesting at its own release SHALL be eligible again, at lowest priority.
REQ-025 req changes on non-granted bits SHALL NOT affect an ongoing grant; no preemption.
REQ-026 grant SHALL never have more than one bit set, and select SHALL always equal the index of the set grant bit.
REQ-027 MAX_BURST=1 SHALL release after every beat; last=1 on every beat.

Reset
REQ-028 reset=1 at an edge SHALL force state=IDLE, grant=0, select=0, out_valid=0, last=0, busy=0, ptr=0, cnt=0.
REQ-029 reset SHALL take priority over any beat, release or arbitration in the same cycle; a beat coincident with reset is not counted.
REQ-030 Arbitration SHALL resume on the first edge after reset deasserts, using ptr=0.

Verification
REQ-031 After reset, req=0001, in0=5, ready=1 held -> grant=0001 from cycle 2; out=5 on every beat; last on every 4th beat; regrant to 0 with no bubble.
REQ-032 req=1111 held, ready=1 -> grants 0,1,2,3,0 in order, 4 beats each, out_valid continuously 1.
REQ-033 Granted 2, cnt=1, ready=0 for 3 cycles, in2 changes 7->9 -> out_valid=1 and select=2 held, out=9, cnt stays 1, then 3 more beats on ready=1.
REQ-034 Granted 0, req[0] dropped after 2 beats while req=0110 -> grant=0010 on the next cycle, ptr=1.
REQ-035 After a grant to 1 (ptr=2), req=1011 held -> grants 3, then 0, then 1.
REQ-036 reset=1 mid-burst with ready=1 -> next cycle grant=0, out_valid=0, busy=0, and the following grant starts with cnt=0, ptr=0.
